// File: rtl/vector_regfile_if.sv
// rtl/vector_regfile_if.sv - read/write/scoreboard signal bundle for vector_regfile
interface vector_regfile_if #(
    parameter int NUM_REGS = 4,
    parameter int LANES    = 4,
    parameter int LANE_W   = 32
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                      rd_en;
    logic                      rd_ready;
    logic [1:0]                x_sel;
    logic [IDX_W-1:0]          x_idx;
    logic [LSEL_W-1:0]         x_lane;
    logic [1:0]                y_sel;
    logic [IDX_W-1:0]          y_idx;
    logic [LSEL_W-1:0]         y_lane;
    logic [LANE_W-1:0]         imm;
    logic                      rd_valid;
    logic [LANE_W-1:0]         x_data;
    logic [LANE_W-1:0]         y_data;
    logic                      wr_en;
    logic [IDX_W-1:0]          wr_idx;
    logic [LANES-1:0]          wr_mask;
    logic [LANES*LANE_W-1:0]   wr_data;
    logic                      ar_we;
    logic [LANE_W-1:0]         ar_din;
    logic                      bpr_we;
    logic [LANE_W-1:0]         bpr_din;
    logic                      pend_set;
    logic [IDX_W-1:0]          pend_idx;
    logic [NUM_REGS-1:0]       pending;

    modport master (
        output rd_en, x_sel, x_idx, x_lane, y_sel, y_idx, y_lane, imm,
        output wr_en, wr_idx, wr_mask, wr_data, ar_we, ar_din, bpr_we, bpr_din,
        output pend_set, pend_idx,
        input  rd_ready, rd_valid, x_data, y_data, pending
    );

    modport slave (
        input  rd_en, x_sel, x_idx, x_lane, y_sel, y_idx, y_lane, imm,
        input  wr_en, wr_idx, wr_mask, wr_data, ar_we, ar_din, bpr_we, bpr_din,
        input  pend_set, pend_idx,
        output rd_ready, rd_valid, x_data, y_data, pending
    );
endinterface

// File: rtl/vector_regfile.sv
// rtl/vector_regfile.sv - vector register file with lane reads, masked writes, forwarding and load scoreboard
module vector_regfile #(
    parameter int NUM_REGS = 4,
    parameter int LANES    = 4,
    parameter int LANE_W   = 32
) (
    input logic              clk,
    input logic              rst_n,
    vector_regfile_if.slave  bus
);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int LSEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0]       vreg [NUM_REGS][LANES];
    logic [LANE_W-1:0]       ar_q, bpr_q, x_q, y_q;
    logic [LANE_W-1:0]       ar_nx, bpr_nx, x_val, y_val;
    logic [NUM_REGS-1:0]     pend_q;
    logic                    rd_valid_q, x_blk, y_blk, rd_ready, accept;

    logic                    wr_en;
    logic [IDX_W-1:0]        wr_idx;
    logic [LANES-1:0]        wr_mask;
    logic [LANES*LANE_W-1:0] wr_data;

    assign wr_en   = bus.wr_en;
    assign wr_idx  = bus.wr_idx;
    assign wr_mask = bus.wr_mask;
    assign wr_data = bus.wr_data;

    // True when this cycle's write lands on the given register lane.
    function automatic logic wr_hits(input logic [IDX_W-1:0] idx, input logic [LSEL_W-1:0] lane);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < LANES; l++)
            if (wr_en && wr_idx == idx && lane == LSEL_W'(l) && wr_mask[l])
                hit = 1'b1;
        return hit;
    endfunction

    // Only in-range register/lane pairs match, so anything else reads as zero.
    function automatic logic [LANE_W-1:0] vec_read(input logic [IDX_W-1:0] idx, input logic [LSEL_W-1:0] lane);
        logic [LANE_W-1:0] val;
        val = '0;
        for (int r = 0; r < NUM_REGS; r++)
            for (int l = 0; l < LANES; l++)
                if (idx == IDX_W'(r) && lane == LSEL_W'(l))
                    val = wr_hits(idx, lane) ? wr_data[l*LANE_W +: LANE_W] : vreg[r][l];
        return val;
    endfunction

    function automatic logic blocked(input logic [1:0] sel, input logic [IDX_W-1:0] idx,
                                     input logic [LSEL_W-1:0] lane);
        logic pend;
        pend = 1'b0;
        for (int r = 0; r < NUM_REGS; r++)
            if (idx == IDX_W'(r))
                pend = pend_q[r];
        return (sel == 2'd0) && pend && !wr_hits(idx, lane);
    endfunction

    assign ar_nx    = bus.ar_we  ? bus.ar_din  : ar_q;
    assign bpr_nx   = bus.bpr_we ? bus.bpr_din : bpr_q;
    assign x_blk    = blocked(bus.x_sel, bus.x_idx, bus.x_lane);
    assign y_blk    = blocked(bus.y_sel, bus.y_idx, bus.y_lane);
    assign rd_ready = !(x_blk || y_blk);
    assign accept   = bus.rd_en && rd_ready;

    always_comb begin
        x_val = '0;
        case (bus.x_sel)
            2'd0:    x_val = vec_read(bus.x_idx, bus.x_lane);
            2'd1:    x_val = bpr_nx;
            2'd2:    x_val = ar_nx;
            default: x_val = '0;
        endcase
    end

    always_comb begin
        y_val = '0;
        case (bus.y_sel)
            2'd0:    y_val = vec_read(bus.y_idx, bus.y_lane);
            2'd1:    y_val = bpr_nx;
            2'd2:    y_val = bus.imm;
            default: y_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                for (int l = 0; l < LANES; l++)
                    vreg[r][l] <= '0;
            ar_q       <= '0;
            bpr_q      <= '0;
            pend_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int l = 0; l < LANES; l++)
                    if (wr_en && wr_idx == IDX_W'(r) && wr_mask[l])
                        vreg[r][l] <= wr_data[l*LANE_W +: LANE_W];
                // A load issued in the same cycle as a write outranks the clear.
                if (wr_en && wr_idx == IDX_W'(r))
                    pend_q[r] <= 1'b0;
                if (bus.pend_set && bus.pend_idx == IDX_W'(r))
                    pend_q[r] <= 1'b1;
            end
            ar_q       <= ar_nx;
            bpr_q      <= bpr_nx;
            rd_valid_q <= accept;
            if (accept) begin
                x_q <= x_val;
                y_q <= y_val;
            end
        end
    end

    assign bus.rd_ready = rd_ready;
    assign bus.rd_valid = rd_valid_q;
    assign bus.x_data   = x_q;
    assign bus.y_data   = y_q;
    assign bus.pending  = pend_q;
endmodule
